reg_file_param: RTL and testbench

Parametrised multi-port register file for the datapath: one write port, two independently enabled read ports with registered outputs, optional hard-wired zero register, and a self-timed clear sequencer that zeroes the whole array without a reset. It is the next-generation register file and feeds the ALU operand buses. The write port is driven from writeback.

---
 rtl/reg_file_param.sv | 159 +++++++++++++++
 tb/tb_reg_file_param.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with one write port, two independently
// enabled registered read ports, optional hard-wired zero register and a self-timed
// clear sequencer that zeroes the array one word per cycle.
// Optional build macro: REG_FILE_BYPASS_EN forwards same-edge writes/clears to the
// read ports. Without it, a same-edge read sees the pre-edge contents.
module reg_file_param #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  d_in,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              clr,
  output logic [WIDTH-1:0]  d_out_a,
  output logic [WIDTH-1:0]  d_out_b,
  output logic              vld_a,
  output logic              vld_b,
  output logic              busy,
  output logic              wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              wr_drop_q, wr_drop_d;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];

  logic [WIDTH-1:0]  d_out_a_q, d_out_a_d;
  logic [WIDTH-1:0]  d_out_b_q, d_out_b_d;
  logic              vld_a_q, vld_a_d;
  logic              vld_b_q, vld_b_d;

  logic              clearing;
  logic              wr_ok;

  // Write qualification: clr wins over wr; zero-register writes vanish without a drop.
  always_comb begin
    clearing  = (state_q == StClear);
    wr_ok     = wr && (state_q == StIdle) && !clr && !(ZERO_REG && (wr_addr == '0));
    wr_drop_d = wr && (clearing || clr);
  end

  // Clear sequencer next state: sweep pointer walks 0..DEPTH-1, then back to idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (clr) begin
          state_d = StClear;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StClear: begin
        if (&ptr_q) begin
          state_d = StIdle;
          ptr_d   = '0;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Array next state: sweep clear and accepted write never coincide.
  always_comb begin
    mem_d = mem_q;
    if (clearing) mem_d[ptr_q] = '0;
    if (wr_ok)    mem_d[wr_addr] = d_in;
  end

  // Read word for one port, including optional same-edge forwarding.
  function automatic logic [WIDTH-1:0] rd_word(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] w;
    w = mem_q[addr];
`ifdef REG_FILE_BYPASS_EN
    if (clearing && (addr == ptr_q))  w = '0;
    if (wr_ok && (addr == wr_addr))   w = d_in;
`endif
    if (ZERO_REG && (addr == '0))     w = '0;
    return w;
  endfunction

  // Read ports: load on request, otherwise hold data and drop valid.
  always_comb begin
    vld_a_d   = rd_en_a;
    vld_b_d   = rd_en_b;
    d_out_a_d = rd_en_a ? rd_word(rd_addr_a) : d_out_a_q;
    d_out_b_d = rd_en_b ? rd_word(rd_addr_b) : d_out_b_q;
  end

  // FSM and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out_a_q <= '0;
      d_out_b_q <= '0;
      vld_a_q   <= 1'b0;
      vld_b_q   <= 1'b0;
    end else begin
      d_out_a_q <= d_out_a_d;
      d_out_b_q <= d_out_b_d;
      vld_a_q   <= vld_a_d;
      vld_b_q   <= vld_b_d;
    end
  end

  assign d_out_a = d_out_a_q;
  assign d_out_b = d_out_b_q;
  assign vld_a   = vld_a_q;
  assign vld_b   = vld_b_q;
  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param. Two instances share stimulus: dut0 has
// ZERO_REG = 0, dut1 has ZERO_REG = 1. Each read pushes a pair of expected words
// (dut0, dut1) at the issuing edge; a negedge monitor pops and compares.
module tb_reg_file_param;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic [2:0]  wr_addr;
  logic [15:0] d_in;
  logic        rd_en_a, rd_en_b;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic        clr;

  logic [15:0] d_out_a0, d_out_b0, d_out_a1, d_out_b1;
  logic        vld_a0, vld_b0, vld_a1, vld_b1;
  logic        busy0, busy1, wr_drop0, wr_drop1;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] pend_a, pend_b;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  reg_file_param #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .clr(clr), .d_out_a(d_out_a0), .d_out_b(d_out_b0), .vld_a(vld_a0), .vld_b(vld_b0),
    .busy(busy0), .wr_drop(wr_drop0)
  );

  reg_file_param #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .clr(clr), .d_out_a(d_out_a1), .d_out_b(d_out_b1), .vld_a(vld_a1), .vld_b(vld_b1),
    .busy(busy1), .wr_drop(wr_drop1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr      = 1'b0;
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic do_wr(input logic [2:0] a, input logic [15:0] d);
    wr      = 1'b1;
    wr_addr = a;
    d_in    = d;
  endtask

  task automatic rd_a(input logic [2:0] a, input logic [15:0] e0, input logic [15:0] e1);
    rd_en_a   = 1'b1;
    rd_addr_a = a;
    pend_a    = {e0, e1};
  endtask

  task automatic rd_b(input logic [2:0] a, input logic [15:0] e0, input logic [15:0] e1);
    rd_en_b   = 1'b1;
    rd_addr_b = a;
    pend_b    = {e0, e1};
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy0; i++) cyc();
    chk("sweep_end", {31'd0, busy0}, 32'd0);
  endtask

  // Count post-edge cycles with busy high, starting right after the clr edge.
  task automatic count_busy(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy0) break;
      n++;
      cyc();
    end
    chk(name, n, 32'd8);
  endtask

  // Expectation capture at the issuing edge.
  always @(posedge clk) begin
    if (!reset && rd_en_a) qa.push_back(pend_a);
    if (!reset && rd_en_b) qb.push_back(pend_b);
  end

  // Monitor: compare whenever a read result is due, otherwise valid must be low.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset) begin
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("vld_a", {31'd0, vld_a0}, 32'd1);
        chk("vld_a_zr", {31'd0, vld_a1}, 32'd1);
        chk("rd_a", {16'd0, d_out_a0}, {16'd0, e[31:16]});
        chk("rd_a_zr", {16'd0, d_out_a1}, {16'd0, e[15:0]});
      end else begin
        chk("vld_a_idle", {31'd0, vld_a0}, 32'd0);
      end
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("vld_b", {31'd0, vld_b0}, 32'd1);
        chk("vld_b_zr", {31'd0, vld_b1}, 32'd1);
        chk("rd_b", {16'd0, d_out_b0}, {16'd0, e[31:16]});
        chk("rd_b_zr", {16'd0, d_out_b1}, {16'd0, e[15:0]});
      end else begin
        chk("vld_b_idle", {31'd0, vld_b0}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    wr_addr = '0; d_in = '0; rd_addr_a = '0; rd_addr_b = '0;
    pend_a = '0; pend_b = '0;
    idle();
    #12;
    chk("rst_d_out_a", {16'd0, d_out_a0}, 32'd0);
    chk("rst_d_out_b", {16'd0, d_out_b0}, 32'd0);
    chk("rst_vld", {30'd0, vld_a0, vld_b0}, 32'd0);
    chk("rst_busy_drop", {30'd0, busy0, wr_drop0}, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    // Basic write then dual read
    do_wr(3'd3, 16'h1234); cyc();
    do_wr(3'd5, 16'hBEEF); cyc();
    idle();
    rd_a(3'd3, 16'h1234, 16'h1234); rd_b(3'd5, 16'hBEEF, 16'hBEEF); cyc();
    idle(); cyc();
    chk("vld_a_low", {31'd0, vld_a0}, 32'd0);
    chk("hold_a", {16'd0, d_out_a0}, 32'h1234);
    chk("hold_b", {16'd0, d_out_b0}, 32'hBEEF);

    // Same-edge read/write hazard
    do_wr(3'd2, 16'h0001); cyc();
    do_wr(3'd2, 16'h00FF);
    rd_a(3'd2, BYP ? 16'h00FF : 16'h0001, BYP ? 16'h00FF : 16'h0001); cyc();
    idle();
    rd_b(3'd2, 16'h00FF, 16'h00FF); cyc();
    idle(); cyc();

    // Fill and clear sweep
    for (int i = 0; i < 8; i++) begin
      do_wr(3'(i), 16'hAAAA); cyc();
    end
    idle();
    rd_a(3'd0, 16'hAAAA, 16'h0000); rd_b(3'd7, 16'hAAAA, 16'hAAAA); cyc();
    idle();
    clr = 1'b1; cyc();
    clr = 1'b0;
    begin
      int n;
      n = 0;
      for (int i = 0; i < 20; i++) begin
        if (!busy0) break;
        n++;
        idle();
        if (i == 2) begin
          // Edge clearing r2: dropped write, read of the word being cleared
          do_wr(3'd1, 16'h1111);
          rd_a(3'd2, BYP ? 16'h0000 : 16'hAAAA, BYP ? 16'h0000 : 16'hAAAA);
          rd_b(3'd0, 16'h0000, 16'h0000);
        end
        cyc();
        if (i == 2) chk("wr_drop_sweep", {31'd0, wr_drop0}, 32'd1);
        if (i == 3) chk("wr_drop_pulse", {31'd0, wr_drop0}, 32'd0);
      end
      chk("busy_len", n, 32'd8);
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      rd_a(3'(2 * k), 16'h0000, 16'h0000); rd_b(3'(2 * k + 1), 16'h0000, 16'h0000); cyc();
    end
    idle(); cyc();

    // Write/clear collision
    do_wr(3'd4, 16'h5555); clr = 1'b1; cyc();
    idle();
    chk("collide_drop", {31'd0, wr_drop0}, 32'd1);
    chk("collide_busy", {31'd0, busy0}, 32'd1);
    wait_idle();
    rd_a(3'd4, 16'h0000, 16'h0000); cyc();
    idle();
    do_wr(3'd4, 16'h5555); cyc();
    idle();
    rd_b(3'd4, 16'h5555, 16'h5555); cyc();
    idle(); cyc();

    // Zero register
    do_wr(3'd7, 16'h7777); cyc();
    do_wr(3'd0, 16'hFFFF); cyc();
    idle();
    chk("zr_no_drop0", {31'd0, wr_drop0}, 32'd0);
    chk("zr_no_drop1", {31'd0, wr_drop1}, 32'd0);
    rd_a(3'd0, 16'hFFFF, 16'h0000); rd_b(3'd7, 16'h7777, 16'h7777); cyc();
    rd_a(3'd7, 16'h7777, 16'h7777); rd_b(3'd0, 16'hFFFF, 16'h0000); cyc();
    idle();
    do_wr(3'd0, 16'h0F0F); rd_a(3'd0, BYP ? 16'h0F0F : 16'hFFFF, 16'h0000); cyc();
    idle();
    rd_b(3'd0, 16'h0F0F, 16'h0000); cyc();
    idle(); cyc();

    // Reset mid-sweep
    rd_a(3'd7, 16'h7777, 16'h7777); rd_b(3'd7, 16'h7777, 16'h7777); cyc();
    idle(); cyc();
    clr = 1'b1; cyc();
    clr = 1'b0; cyc(); cyc();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", {30'd0, busy0, busy1}, 32'd0);
    chk("mid_rst_d_out_a", {16'd0, d_out_a0}, 32'd0);
    chk("mid_rst_d_out_b", {16'd0, d_out_b0}, 32'd0);
    chk("mid_rst_vld", {30'd0, vld_a0, vld_b0}, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    rd_a(3'd7, 16'h0000, 16'h0000); rd_b(3'd4, 16'h0000, 16'h0000); cyc();
    idle();
    clr = 1'b1; cyc();
    idle();
    count_busy("busy_len_after_rst");
    cyc(); cyc();
    chk("queue_a_empty", qa.size(), 32'd0);
    chk("queue_b_empty", qb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
